// File: rtl/fce_pkg.sv
// Shared encodings, increments and default thresholds for the CAN fault-confinement block.
package fce_pkg;

  typedef logic [1:0] fce_state_t;

  localparam fce_state_t ST_ERROR_ACTIVE  = 2'd0;
  localparam fce_state_t ST_ERROR_PASSIVE = 2'd1;
  localparam fce_state_t ST_BUS_OFF       = 2'd2;

  localparam int TEC_ERR_INC = 8;
  localparam int REC_ERR_INC = 1;
  localparam int REC_DOM_INC = 8;
  localparam int REC_RELOAD  = 120;

  localparam int DEF_WARN_LEVEL     = 96;
  localparam int DEF_PASSIVE_LEVEL  = 128;
  localparam int DEF_BUSOFF_LEVEL   = 256;
  localparam int DEF_RECOVERY_COUNT = 128;

  localparam int TEC_W  = 9;
  localparam int REC_W  = 8;
  localparam int RCNT_W = 7;

  // Saturating add on plain integers; callers narrow the result.
  function automatic int sat_add(input int a, input int b, input int lim);
    return (a + b > lim) ? lim : a + b;
  endfunction

endpackage

// File: rtl/fce_recovery_counter.sv
// Counts armed rec11 pulses while bus-off; done fires on the RECOVERY_COUNT-th pulse.
module fce_recovery_counter
  import fce_pkg::*;
#(
  parameter int RECOVERY_COUNT = DEF_RECOVERY_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [RCNT_W-1:0] LAST = RCNT_W'(RECOVERY_COUNT - 1);

  logic [RCNT_W-1:0] cnt;

  assign done = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || done) cnt <= '0;
    else if (en)          cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fault_confinement.sv
// CAN fault confinement: TEC/REC counters, active/passive/bus-off FSM and bus-off recovery.
// Build option FCE_AUTO_RECOVERY_EN arms recovery automatically on bus-off entry.
module fault_confinement
  import fce_pkg::*;
#(
  parameter int WARN_LEVEL     = DEF_WARN_LEVEL,
  parameter int PASSIVE_LEVEL  = DEF_PASSIVE_LEVEL,
  parameter int BUSOFF_LEVEL   = DEF_BUSOFF_LEVEL,
  parameter int RECOVERY_COUNT = DEF_RECOVERY_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_err,
  input  logic             rx_err,
  input  logic             rx_err_dom,
  input  logic             tx_ok,
  input  logic             rx_ok,
  input  logic             rec11,
  input  logic             rsp,
  output logic [TEC_W-1:0] tec,
  output logic [REC_W-1:0] rec,
  output logic             bof,
  output logic             era,
  output logic             erp,
  output logic             war
);

  localparam int REC_MAX = (1 << REC_W) - 1;

  fce_state_t       state, state_n;
  logic [TEC_W-1:0] tec_n;
  logic [REC_W-1:0] rec_n;
  logic             armed, armed_n;
  logic             rcv_en, rcv_clr, rcv_done;
  logic             bof_n, era_n, erp_n, war_n;

  assign rcv_en  = (state == ST_BUS_OFF) && armed && rec11;
  assign rcv_clr = (state != ST_BUS_OFF);

  fce_recovery_counter #(
    .RECOVERY_COUNT(RECOVERY_COUNT)
  ) u_rcv (
    .clk  (clk),
    .rst  (rst),
    .clr  (rcv_clr),
    .en   (rcv_en),
    .done (rcv_done)
  );

  // Counter update: error pulses beat ok pulses, rsp beats everything outside bus-off.
  always_comb begin
    tec_n = tec;
    rec_n = rec;
    if (state == ST_BUS_OFF) begin
      if (rcv_done) begin
        tec_n = '0;
        rec_n = '0;
      end
    end else if (rsp) begin
      tec_n = '0;
      rec_n = '0;
    end else begin
      if (tx_err)
        tec_n = TEC_W'(sat_add(int'(tec), TEC_ERR_INC, BUSOFF_LEVEL));
      else if (tx_ok && (tec != '0))
        tec_n = tec - 1'b1;

      if (rx_err_dom)
        rec_n = REC_W'(sat_add(int'(rec), REC_DOM_INC, REC_MAX));
      else if (rx_err)
        rec_n = REC_W'(sat_add(int'(rec), REC_ERR_INC, REC_MAX));
      else if (rx_ok) begin
        if (int'(rec) >= PASSIVE_LEVEL) rec_n = REC_W'(REC_RELOAD);
        else if (rec != '0)             rec_n = rec - 1'b1;
      end
    end
  end

  // Next state from next-cycle counter values.
  always_comb begin
    state_n = state;
    case (state)
      ST_BUS_OFF: if (rcv_done) state_n = ST_ERROR_ACTIVE;
      default: begin
        if (int'(tec_n) >= BUSOFF_LEVEL)
          state_n = ST_BUS_OFF;
        else if ((int'(tec_n) >= PASSIVE_LEVEL) || (int'(rec_n) >= PASSIVE_LEVEL))
          state_n = ST_ERROR_PASSIVE;
        else
          state_n = ST_ERROR_ACTIVE;
      end
    endcase
  end

  always_comb begin
    armed_n = armed;
`ifdef FCE_AUTO_RECOVERY_EN
    if (rcv_done)
      armed_n = 1'b0;
    else if ((state != ST_BUS_OFF) && (state_n == ST_BUS_OFF))
      armed_n = 1'b1;
`else
    if (rcv_done)
      armed_n = 1'b0;
    else if ((state == ST_BUS_OFF) && rsp)
      armed_n = 1'b1;
`endif
  end

  always_comb begin
    bof_n = (state_n == ST_BUS_OFF);
    erp_n = (state_n == ST_ERROR_PASSIVE);
    era_n = !bof_n && !erp_n;
    war_n = (int'(tec_n) >= WARN_LEVEL) || (int'(rec_n) >= WARN_LEVEL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ERROR_ACTIVE;
      tec   <= '0;
      rec   <= '0;
      armed <= 1'b0;
      bof   <= 1'b0;
      era   <= 1'b1;
      erp   <= 1'b0;
      war   <= 1'b0;
    end else begin
      state <= state_n;
      tec   <= tec_n;
      rec   <= rec_n;
      armed <= armed_n;
      bof   <= bof_n;
      era   <= era_n;
      erp   <= erp_n;
      war   <= war_n;
    end
  end

endmodule

// File: tb/tb_fault_confinement.sv
// Bench for fault_confinement: directed vector table, hand-written reset corner, randomized run vs model.
module tb_fault_confinement;

  logic       clk, rst;
  logic       tx_err, rx_err, rx_err_dom, tx_ok, rx_ok, rec11, rsp;
  logic [8:0] tec;
  logic [7:0] rec;
  logic       bof, era, erp, war;

  fault_confinement dut (
    .clk(clk), .rst(rst),
    .tx_err(tx_err), .rx_err(rx_err), .rx_err_dom(rx_err_dom),
    .tx_ok(tx_ok), .rx_ok(rx_ok), .rec11(rec11), .rsp(rsp),
    .tec(tec), .rec(rec), .bof(bof), .era(era), .erp(erp), .war(war)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // event bits {rsp, rec11, rx_ok, rx_err_dom, rx_err, tx_ok, tx_err}
  localparam logic [6:0] TXE = 7'd1, TXO = 7'd2, RXE = 7'd4, RXD = 7'd8,
                         RXO = 7'd16, R11 = 7'd32, RSP = 7'd64;

  typedef struct {
    string      nm;
    logic [6:0] ev;
    int         reps;
    int         e_tec;
    int         e_rec;
    logic [3:0] e_flg; // {bof, era, erp, war}
  } vec_t;

  vec_t vq[$];
  int   n_pass = 0, n_tot = 0;

  // Reference model: plain integers following the confinement rules.
  int m_tec, m_rec, m_cnt;
  bit m_bo, m_armed;

  task automatic model_reset();
    m_tec = 0; m_rec = 0; m_cnt = 0; m_bo = 0; m_armed = 0;
  endtask

  task automatic model_step(input logic [6:0] ev);
    if (m_bo) begin
      if (m_armed && ev[5]) m_cnt++;
`ifndef FCE_AUTO_RECOVERY_EN
      if (ev[6]) m_armed = 1;
`endif
      if (m_cnt == 128) begin
        m_bo = 0; m_tec = 0; m_rec = 0; m_cnt = 0; m_armed = 0;
      end
    end else if (ev[6]) begin
      m_tec = 0; m_rec = 0;
    end else begin
      if (ev[0])      m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
      else if (ev[1]) m_tec = (m_tec > 0) ? m_tec - 1 : 0;
      if (ev[3])      m_rec = (m_rec + 8 > 255) ? 255 : m_rec + 8;
      else if (ev[2]) m_rec = (m_rec + 1 > 255) ? 255 : m_rec + 1;
      else if (ev[4]) m_rec = (m_rec > 127) ? 120 : ((m_rec > 0) ? m_rec - 1 : 0);
      if (m_tec >= 256) begin
        m_bo = 1;
`ifdef FCE_AUTO_RECOVERY_EN
        m_armed = 1;
`endif
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_out(input string nm, input int e_tec, input int e_rec, input logic [3:0] f);
    chk({nm, " tec"}, int'(tec), e_tec);
    chk({nm, " rec"}, int'(rec), e_rec);
    chk({nm, " bof"}, int'(bof), int'(f[3]));
    chk({nm, " era"}, int'(era), int'(f[2]));
    chk({nm, " erp"}, int'(erp), int'(f[1]));
    chk({nm, " war"}, int'(war), int'(f[0]));
  endtask

  task automatic chk_model(input string nm);
    logic [3:0] f;
    f[3] = m_bo;
    f[1] = !m_bo && (m_tec >= 128 || m_rec >= 128);
    f[2] = !m_bo && !f[1];
    f[0] = (m_tec >= 96) || (m_rec >= 96);
    chk_out(nm, m_tec, m_rec, f);
  endtask

  task automatic cyc(input logic [6:0] ev);
    {rsp, rec11, rx_ok, rx_err_dom, rx_err, tx_ok, tx_err} = ev;
    @(posedge clk); #1;
    model_step(ev);
    {rsp, rec11, rx_ok, rx_err_dom, rx_err, tx_ok, tx_err} = '0;
  endtask

  task automatic add(input string nm, input logic [6:0] ev, input int reps,
                     input int t, input int r, input logic [3:0] f);
    vec_t v;
    v.nm = nm; v.ev = ev; v.reps = reps; v.e_tec = t; v.e_rec = r; v.e_flg = f;
    vq.push_back(v);
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    {rsp, rec11, rx_ok, rx_err_dom, rx_err, tx_ok, tx_err} = '0;
    model_reset();
    #12;
    chk_out("reset", 0, 0, 4'b0100);
    rst = 1'b0;

    add("tx_err x12",      TXE,       12,  96,   0, 4'b0101);
    add("tx_err x16",      TXE,        4, 128,   0, 4'b0011);
    add("tx_ok at 128",    TXO,        1, 127,   0, 4'b0101);
    add("rsp clears",      RSP,        1,   0,   0, 4'b0100);
    add("tx_err+tx_ok",    TXE | TXO,  1,   8,   0, 4'b0100);
    add("tx_err to 104",   TXE,       12, 104,   0, 4'b0101);
    add("tx_ok to 100",    TXO,        4, 100,   0, 4'b0101);
    add("rsp at 100",      RSP,        1,   0,   0, 4'b0100);
    add("tx_err x32",      TXE,       32, 256,   0, 4'b1001);
    add("busoff tx_err",   TXE,        2, 256,   0, 4'b1001);
    add("busoff tx_ok",    TXO,        3, 256,   0, 4'b1001);
    add("busoff rx",       RXE | RXD | RXO, 3, 256, 0, 4'b1001);
`ifndef FCE_AUTO_RECOVERY_EN
    add("rec11 unarmed",   R11,      200, 256,   0, 4'b1001);
    add("rsp in busoff",   RSP,        1, 256,   0, 4'b1001);
`endif
    add("rec11 x127",      R11,      127, 256,   0, 4'b1001);
    add("rec11 128th",     R11,        1,   0,   0, 4'b0100);
    add("rx_dom x16",      RXD,       16,   0, 128, 4'b0011);
    add("rx_err x2",       RXE,        2,   0, 130, 4'b0011);
    add("rx_ok reload",    RXO,        1,   0, 120, 4'b0101);
    add("rx_err x260",     RXE,      260,   0, 255, 4'b0011);
    add("rx_ok again",     RXO,        1,   0, 120, 4'b0101);
    add("rx_dom+rx_err",   RXE | RXD,  1,   0, 128, 4'b0011);
    add("rx_err+rx_ok",    RXE | RXO,  1,   0, 129, 4'b0011);
    add("rsp clears rec",  RSP,        1,   0,   0, 4'b0100);
    add("rx_ok at 0",      RXO,        1,   0,   0, 4'b0100);
    add("tx/rx indep",     TXE | RXO | RXD, 1, 8, 8, 4'b0100);

    foreach (vq[i]) begin
      for (int k = 0; k < vq[i].reps; k++) cyc(vq[i].ev);
      chk_out(vq[i].nm, vq[i].e_tec, vq[i].e_rec, vq[i].e_flg);
    end

    // Asynchronous reset in the middle of bus-off recovery.
    hard_reset();
    for (int k = 0; k < 32; k++) cyc(TXE);
`ifndef FCE_AUTO_RECOVERY_EN
    cyc(RSP);
`endif
    for (int k = 0; k < 64; k++) cyc(R11);
    chk_out("mid recovery", 256, 0, 4'b1001);
    #3 rst = 1'b1;
    #1 chk_out("async rst", 0, 0, 4'b0100);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cyc(TXE);
    chk_out("after rst", 8, 0, 4'b0100);

    // Randomized run against the model.
    hard_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [6:0] ev;
      ev[0] = ($urandom_range(0, 99) < 30);
      ev[1] = ($urandom_range(0, 99) < 30);
      ev[2] = ($urandom_range(0, 99) < 20);
      ev[3] = ($urandom_range(0, 99) < 10);
      ev[4] = ($urandom_range(0, 99) < 30);
      ev[5] = ($urandom_range(0, 99) < 50);
      ev[6] = m_bo ? ($urandom_range(0, 999) < 30) : ($urandom_range(0, 999) < 3);
      cyc(ev);
      chk_model("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
